msi_line_ctrl: RTL and testbench
================================

// Module: msi_line_ctrl
// PURPOSE
//  Multi-line MSI coherence controller for one private cache. Holds state+tag for NUM_LINES
//  direct-mapped lines, services CPU requests (hit/miss decode, victim write-back, bus
//  transaction with req/gnt) and applies snooped bus traffic from other caches.
//  Sits between the CPU load/store port and the shared snooping bus.
// PARAMETERS
//  NUM_LINES  16                  lines in the state/tag array (power of 2, >=2)
//  IDX_W      $clog2(NUM_LINES)   line index width
//  TAG_W      8                   tag width
// PORTS
//  clk          in   1      single clock, all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  cpu_valid    in   1      CPU request present
//  cpu_ready    out  1      controller can accept (high only in IDLE)
//  cpu_rw       in   1      1=write, 0=read
//  cpu_idx      in   IDX_W  line index
//  cpu_tag      in   TAG_W  request tag
//  cpu_done     out  1      one-cycle pulse: request complete
//  cpu_hit      out  1      valid with cpu_done: 1=hit at acceptance
//  bus_req      out  1      bus request, held until bus_gnt
//  bus_gnt      in   1      one-cycle grant; transaction completes on that edge
//  bus_cmd      out  2      00 INVALIDATE, 01 WRITE_MISS, 10 READ_MISS, 11 WRITE_BACK
//  bus_idx      out  IDX_W  index of bus transaction
//  bus_tag      out  TAG_W  tag of bus transaction (victim tag for WRITE_BACK)
//  snoop_valid  in   1      other cache's transaction on bus
//  snoop_cmd    in   2      encoding as bus_cmd
//  snoop_idx    in   IDX_W  snooped index
//  snoop_tag    in   TAG_W  snooped tag
//  snoop_wb     out  1      one-cycle pulse: this cache must supply/flush Modified data
//  dbg_idx      in   IDX_W  debug read index
//  dbg_state    out  2      combinational state of line dbg_idx
// BEHAVIOUR
//  State encoding: INVALID=2'd0, MODIFIED=2'd1, SHARED=2'd2; 2'd3 never stored.
//  Reset: all lines INVALID, tags 0, FSM IDLE; cpu_done, cpu_hit, bus_req, snoop_wb = 0;
//   bus_cmd/idx/tag = 0; cpu_ready=1 first cycle after reset. Reset mid-transaction aborts:
//   no cpu_done, bus_req low next cycle, line states return to INVALID.
//  FSM: IDLE, WB, REQ, DONE. Accept = cpu_valid & cpu_ready; request fields latched.
//  Hit = line state!=INVALID and stored tag==cpu_tag.
//   read hit (M or S)        -> DONE, no bus activity, state unchanged.
//   write hit M              -> DONE, no bus activity.
//   write hit S              -> REQ cmd INVALIDATE; on gnt line->M.
//   miss, victim M           -> WB cmd WRITE_BACK, bus_tag=victim tag; on gnt victim->I,
//                               then REQ.
//   miss, victim I or S      -> REQ directly (S victim dropped silently).
//   REQ read miss            -> cmd READ_MISS; on gnt line->S, tag<=cpu_tag.
//   REQ write miss           -> cmd WRITE_MISS; on gnt line->M, tag<=cpu_tag.
//  bus_req/cmd/idx/tag registered, stable from entry to WB/REQ until gnt edge; bus_req
//   drops the cycle after gnt. DONE lasts one cycle: cpu_done=1, then IDLE.
//  Latency: hit: cpu_done 1 cycle after accept. Miss: cpu_done 1 cycle after final gnt.
//  Snoop (tag match and state!=I), applied at edge:
//   M + READ_MISS -> S, snoop_wb=1;  M + WRITE_MISS -> I, snoop_wb=1;
//   S + WRITE_MISS or INVALIDATE -> I;  WRITE_BACK and all others: no change.
//  Snoop during WB/REQ: if pending INVALIDATE's line is invalidated by snoop, bus_cmd
//   changes to WRITE_MISS next cycle (upgrade lost); bus_req stays high.
//  snoop_valid and bus_gnt are mutually exclusive (arbiter guarantee); simultaneous
//   assertion is a protocol violation flagged by an assertion, behaviour undefined.
//  Hit/miss decided at acceptance; snoops after acceptance only affect the upgrade rule.
// STRUCTURE
//  Package msi_pkg: state_t enum (INVALID/MODIFIED/SHARED), bus_cmd_t enum
//   (BUS_INVALIDATE/BUS_WRITE_MISS/BUS_READ_MISS/BUS_WRITE_BACK), fsm_t enum.
//  Sub-module msi_line_store: state+tag arrays, async read ports (cpu, snoop, dbg),
//   one sync write port each for FSM and snoop path.
// TESTING
//  1 reset, read idx3 tag 0x12 -> READ_MISS idx3, gnt 2 cycles later -> done, hit=0, dbg=S.
//  2 repeat read idx3 tag 0x12 -> cpu_done next cycle, hit=1, no bus_req.
//  3 write idx3 tag 0x12 (S) -> INVALIDATE, gnt -> M; then write idx3 tag 0x34 ->
//    WRITE_BACK tag 0x12, then WRITE_MISS tag 0x34, line M tag 0x34.
//  4 line M idx5 tag 0x7: snoop READ_MISS idx5 tag 0x7 -> snoop_wb pulse, S; snoop
//    WRITE_MISS -> I; snoop with tag 0x8 -> no change.
//  5 write hit S idx2, snoop INVALIDATE idx2 while bus_req held -> bus_cmd becomes
//    WRITE_MISS; gnt -> M, cpu_hit=1.
//  6 rst asserted while bus_req high in REQ -> bus_req 0 next cycle, no cpu_done, all I.

Source files
------------

// File: rtl/msi_line_ctrl_pkg.sv
// Shared types for the MSI line controller: line states, bus commands, FSM states
// and the snoop transition rule used by the controller.
package msi_pkg;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    MODIFIED = 2'd1,
    SHARED   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BUS_INVALIDATE = 2'd0,
    BUS_WRITE_MISS = 2'd1,
    BUS_READ_MISS  = 2'd2,
    BUS_WRITE_BACK = 2'd3
  } bus_cmd_t;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_WB   = 2'd1,
    FSM_REQ  = 2'd2,
    FSM_DONE = 2'd3
  } fsm_t;

  typedef struct packed {
    state_t nxt;
    logic   change;
    logic   flush;
  } snoop_res_t;

  // Reaction of a matching, valid line to another cache's bus command.
  function automatic snoop_res_t snoop_next(state_t cur, bus_cmd_t cmd);
    snoop_res_t r;
    r.nxt    = cur;
    r.change = 1'b0;
    r.flush  = 1'b0;
    if (cur == MODIFIED && cmd == BUS_READ_MISS) begin
      r.nxt    = SHARED;
      r.change = 1'b1;
      r.flush  = 1'b1;
    end else if (cur == MODIFIED && cmd == BUS_WRITE_MISS) begin
      r.nxt    = INVALID;
      r.change = 1'b1;
      r.flush  = 1'b1;
    end else if (cur == SHARED && (cmd == BUS_WRITE_MISS || cmd == BUS_INVALIDATE)) begin
      r.nxt    = INVALID;
      r.change = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/msi_line_ctrl_if.sv
// CPU, bus, snoop and debug signals of the MSI line controller.
// The controller uses the slave modport; its environment uses master.
interface msi_line_ctrl_if #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
);
  logic             cpu_valid;
  logic             cpu_ready;
  logic             cpu_rw;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic             cpu_done;
  logic             cpu_hit;
  logic             bus_req;
  logic             bus_gnt;
  logic [1:0]       bus_cmd;
  logic [IDX_W-1:0] bus_idx;
  logic [TAG_W-1:0] bus_tag;
  logic             snoop_valid;
  logic [1:0]       snoop_cmd;
  logic [IDX_W-1:0] snoop_idx;
  logic [TAG_W-1:0] snoop_tag;
  logic             snoop_wb;
  logic [IDX_W-1:0] dbg_idx;
  logic [1:0]       dbg_state;

  modport slave (
    input  cpu_valid, cpu_rw, cpu_idx, cpu_tag, bus_gnt,
    input  snoop_valid, snoop_cmd, snoop_idx, snoop_tag, dbg_idx,
    output cpu_ready, cpu_done, cpu_hit, bus_req, bus_cmd, bus_idx, bus_tag,
    output snoop_wb, dbg_state
  );

  modport master (
    output cpu_valid, cpu_rw, cpu_idx, cpu_tag, bus_gnt,
    output snoop_valid, snoop_cmd, snoop_idx, snoop_tag, dbg_idx,
    input  cpu_ready, cpu_done, cpu_hit, bus_req, bus_cmd, bus_idx, bus_tag,
    input  snoop_wb, dbg_state
  );
endinterface

// File: rtl/msi_line_ctrl_line_store.sv
// State and tag storage for all lines: three async read ports (cpu, snoop, debug)
// and two synchronous write ports (controller FSM, snoop path).
module msi_line_store
  import msi_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] cpu_idx,
  output state_t           cpu_state,
  output logic [TAG_W-1:0] cpu_tag,
  input  logic [IDX_W-1:0] snp_idx,
  output state_t           snp_state,
  output logic [TAG_W-1:0] snp_tag,
  input  logic [IDX_W-1:0] dbg_idx,
  output state_t           dbg_state,
  input  logic             fsm_we,
  input  logic [IDX_W-1:0] fsm_idx,
  input  state_t           fsm_state,
  input  logic [TAG_W-1:0] fsm_tag,
  input  logic             snp_we,
  input  state_t           snp_wr_state
);

  state_t           state_all [NUM_LINES];
  logic [TAG_W-1:0] tag_all   [NUM_LINES];

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    state_t           state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // Snoop writes never touch the tag; the FSM port wins if both ever hit one line.
    always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      if (fsm_we && fsm_idx == IDX_W'(gi)) begin
        state_d = fsm_state;
        tag_d   = fsm_tag;
      end else if (snp_we && snp_idx == IDX_W'(gi)) begin
        state_d = snp_wr_state;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= INVALID;
        tag_q   <= '0;
      end else begin
        state_q <= state_d;
        tag_q   <= tag_d;
      end
    end

    assign state_all[gi] = state_q;
    assign tag_all[gi]   = tag_q;
  end

  assign cpu_state = state_all[cpu_idx];
  assign cpu_tag   = tag_all[cpu_idx];
  assign snp_state = state_all[snp_idx];
  assign snp_tag   = tag_all[snp_idx];
  assign dbg_state = state_all[dbg_idx];

endmodule

// File: rtl/msi_line_ctrl.sv
// MSI coherence controller for a direct-mapped private cache: decodes CPU hits and
// misses, runs write-back / bus transactions, and applies snooped traffic.
module msi_line_ctrl
  import msi_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  msi_line_ctrl_if.slave io
);

  state_t           cpu_line_state, snp_line_state, dbg_line_state;
  logic [TAG_W-1:0] cpu_line_tag, snp_line_tag;

  fsm_t             fsm_q, fsm_d;
  logic             rw_q, rw_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             hit_q, hit_d;
  logic             cpu_done_q, cpu_done_d;
  logic             cpu_hit_q, cpu_hit_d;
  logic             bus_req_q, bus_req_d;
  bus_cmd_t         bus_cmd_q, bus_cmd_d;
  logic [IDX_W-1:0] bus_idx_q, bus_idx_d;
  logic [TAG_W-1:0] bus_tag_q, bus_tag_d;
  logic             snoop_wb_q, snoop_wb_d;

  logic             fsm_we;
  state_t           fsm_wr_state;
  logic [TAG_W-1:0] fsm_wr_tag;

  snoop_res_t       snp_res;
  logic             snp_match, snp_we, snp_kill;
  logic             cpu_is_hit;

  msi_line_store #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .cpu_idx     (io.cpu_idx),
    .cpu_state   (cpu_line_state),
    .cpu_tag     (cpu_line_tag),
    .snp_idx     (io.snoop_idx),
    .snp_state   (snp_line_state),
    .snp_tag     (snp_line_tag),
    .dbg_idx     (io.dbg_idx),
    .dbg_state   (dbg_line_state),
    .fsm_we      (fsm_we),
    .fsm_idx     (idx_q),
    .fsm_state   (fsm_wr_state),
    .fsm_tag     (fsm_wr_tag),
    .snp_we      (snp_we),
    .snp_wr_state(snp_res.nxt)
  );

  assign snp_match  = io.snoop_valid && snp_line_state != INVALID && snp_line_tag == io.snoop_tag;
  assign snp_res    = snoop_next(snp_line_state, bus_cmd_t'(io.snoop_cmd));
  assign snp_we     = snp_match && snp_res.change;
  assign snp_kill   = snp_we && snp_res.nxt == INVALID;
  assign snoop_wb_d = snp_match && snp_res.flush;
  assign cpu_is_hit = cpu_line_state != INVALID && cpu_line_tag == io.cpu_tag;

  always_comb begin
    fsm_d        = fsm_q;
    rw_d         = rw_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    hit_d        = hit_q;
    cpu_done_d   = 1'b0;
    cpu_hit_d    = 1'b0;
    bus_req_d    = bus_req_q;
    bus_cmd_d    = bus_cmd_q;
    bus_idx_d    = bus_idx_q;
    bus_tag_d    = bus_tag_q;
    fsm_we       = 1'b0;
    fsm_wr_state = INVALID;
    fsm_wr_tag   = tag_q;

    unique case (fsm_q)
      FSM_IDLE: begin
        if (io.cpu_valid) begin
          rw_d      = io.cpu_rw;
          idx_d     = io.cpu_idx;
          tag_d     = io.cpu_tag;
          hit_d     = cpu_is_hit;
          bus_idx_d = io.cpu_idx;
          if (cpu_is_hit && (!io.cpu_rw || cpu_line_state == MODIFIED)) begin
            fsm_d      = FSM_DONE;
            cpu_done_d = 1'b1;
            cpu_hit_d  = 1'b1;
          end else if (cpu_is_hit) begin
            // A snoop killing this very line on the accept edge already loses the upgrade.
            fsm_d     = FSM_REQ;
            bus_req_d = 1'b1;
            bus_cmd_d = (snp_kill && io.snoop_idx == io.cpu_idx) ? BUS_WRITE_MISS
                                                                  : BUS_INVALIDATE;
            bus_tag_d = io.cpu_tag;
          end else if (cpu_line_state == MODIFIED) begin
            fsm_d     = FSM_WB;
            bus_req_d = 1'b1;
            bus_cmd_d = BUS_WRITE_BACK;
            bus_tag_d = cpu_line_tag;
          end else begin
            fsm_d     = FSM_REQ;
            bus_req_d = 1'b1;
            bus_cmd_d = io.cpu_rw ? BUS_WRITE_MISS : BUS_READ_MISS;
            bus_tag_d = io.cpu_tag;
          end
        end
      end

      FSM_WB: begin
        if (io.bus_gnt) begin
          fsm_we       = 1'b1;
          fsm_wr_state = INVALID;
          fsm_wr_tag   = bus_tag_q;
          fsm_d        = FSM_REQ;
          bus_cmd_d    = rw_q ? BUS_WRITE_MISS : BUS_READ_MISS;
          bus_tag_d    = tag_q;
        end
      end

      FSM_REQ: begin
        if (io.bus_gnt) begin
          fsm_we       = 1'b1;
          fsm_wr_state = (bus_cmd_q == BUS_READ_MISS) ? SHARED : MODIFIED;
          fsm_d        = FSM_DONE;
          cpu_done_d   = 1'b1;
          cpu_hit_d    = hit_q;
          bus_req_d    = 1'b0;
        end else if (bus_cmd_q == BUS_INVALIDATE && snp_kill && io.snoop_idx == idx_q) begin
          bus_cmd_d = BUS_WRITE_MISS;
        end
      end

      FSM_DONE: begin
        fsm_d = FSM_IDLE;
      end

      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= FSM_IDLE;
      rw_q       <= 1'b0;
      idx_q      <= '0;
      tag_q      <= '0;
      hit_q      <= 1'b0;
      cpu_done_q <= 1'b0;
      cpu_hit_q  <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_cmd_q  <= BUS_INVALIDATE;
      bus_idx_q  <= '0;
      bus_tag_q  <= '0;
      snoop_wb_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      rw_q       <= rw_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      hit_q      <= hit_d;
      cpu_done_q <= cpu_done_d;
      cpu_hit_q  <= cpu_hit_d;
      bus_req_q  <= bus_req_d;
      bus_cmd_q  <= bus_cmd_d;
      bus_idx_q  <= bus_idx_d;
      bus_tag_q  <= bus_tag_d;
      snoop_wb_q <= snoop_wb_d;
    end
  end

  assign io.cpu_ready = (fsm_q == FSM_IDLE);
  assign io.cpu_done  = cpu_done_q;
  assign io.cpu_hit   = cpu_hit_q;
  assign io.bus_req   = bus_req_q;
  assign io.bus_cmd   = bus_cmd_q;
  assign io.bus_idx   = bus_idx_q;
  assign io.bus_tag   = bus_tag_q;
  assign io.snoop_wb  = snoop_wb_q;
  assign io.dbg_state = dbg_line_state;

  // The arbiter never grants us while another cache owns the bus.
  a_no_snoop_on_gnt: assert property (@(posedge clk) disable iff (rst)
    !(io.snoop_valid && io.bus_gnt));

endmodule

// File: tb/tb_msi_line_ctrl.sv
// Directed bench for msi_line_ctrl with a transaction-queue reference model that is
// compared against the DUT outputs on every falling edge.
module tb_msi_line_ctrl;

  localparam int NL = 16;
  localparam logic [1:0] C_INV = 2'd0, C_WM = 2'd1, C_RM = 2'd2, C_WB = 2'd3;
  localparam logic [1:0] S_I = 2'd0, S_M = 2'd1, S_S = 2'd2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  msi_line_ctrl_if #(.IDX_W(4), .TAG_W(8)) io ();

  msi_line_ctrl #(.NUM_LINES(NL), .IDX_W(4), .TAG_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-line state/tag plus a queue of bus operations still owed
  // by the outstanding CPU request.
  typedef struct {
    logic [1:0] cmd;
    logic [7:0] tag;
  } op_t;

  op_t        q[$];
  logic [1:0] m_st  [NL];
  logic [7:0] m_tag [NL];
  bit         m_busy, m_hit, m_rw, e_done, e_hit, e_wb, model_on = 0;
  bit         nd, nh, nw, killed;
  logic [3:0] m_idx;
  logic [7:0] m_rtag;
  logic [1:0] s, old_s;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        m_st[i]  = S_I;
        m_tag[i] = 8'h00;
      end
      q.delete();
      m_busy   = 0;
      e_done   = 0;
      e_hit    = 0;
      e_wb     = 0;
      model_on = 1;
    end else if (model_on) begin
      nd = 0; nh = 0; nw = 0; killed = 0;
      if (e_done) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (io.cpu_valid) begin
          m_busy = 1;
          m_rw   = io.cpu_rw;
          m_idx  = io.cpu_idx;
          m_rtag = io.cpu_tag;
          s      = m_st[m_idx];
          m_hit  = (s != S_I) && (m_tag[m_idx] == m_rtag);
          if (m_hit && (!m_rw || s == S_M)) begin
            nd = 1; nh = 1;
          end else if (m_hit) begin
            q.push_back('{C_INV, m_rtag});
          end else begin
            if (s == S_M) q.push_back('{C_WB, m_tag[m_idx]});
            q.push_back('{m_rw ? C_WM : C_RM, m_rtag});
          end
        end
      end else if (q.size() > 0 && io.bus_gnt) begin
        case (q[0].cmd)
          C_WB:    m_st[m_idx] = S_I;
          C_RM:    begin m_st[m_idx] = S_S; m_tag[m_idx] = m_rtag; end
          default: begin m_st[m_idx] = S_M; m_tag[m_idx] = m_rtag; end
        endcase
        void'(q.pop_front());
        if (q.size() == 0) begin
          nd = 1; nh = m_hit;
        end
      end
      if (io.snoop_valid) begin
        old_s = m_st[io.snoop_idx];
        if (old_s != S_I && m_tag[io.snoop_idx] == io.snoop_tag) begin
          if (old_s == S_M && io.snoop_cmd == C_RM) begin
            m_st[io.snoop_idx] = S_S; nw = 1;
          end else if (old_s == S_M && io.snoop_cmd == C_WM) begin
            m_st[io.snoop_idx] = S_I; nw = 1;
          end else if (old_s == S_S && (io.snoop_cmd == C_WM || io.snoop_cmd == C_INV)) begin
            m_st[io.snoop_idx] = S_I;
          end
          killed = (m_st[io.snoop_idx] == S_I) && (io.snoop_idx == m_idx);
        end
        if (m_busy && killed && q.size() > 0 && q[0].cmd == C_INV) q[0].cmd = C_WM;
      end
      e_done = nd;
      e_hit  = nh;
      e_wb   = nw;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("cpu_ready", {31'd0, io.cpu_ready}, {31'd0, !m_busy});
      chk("cpu_done", {31'd0, io.cpu_done}, {31'd0, e_done});
      if (e_done) chk("cpu_hit", {31'd0, io.cpu_hit}, {31'd0, e_hit});
      chk("bus_req", {31'd0, io.bus_req}, {31'd0, (m_busy && !e_done && q.size() > 0)});
      if (m_busy && !e_done && q.size() > 0) begin
        chk("bus_cmd", {30'd0, io.bus_cmd}, {30'd0, q[0].cmd});
        chk("bus_idx", {28'd0, io.bus_idx}, {28'd0, m_idx});
        chk("bus_tag", {24'd0, io.bus_tag}, {24'd0, q[0].tag});
      end
      chk("snoop_wb", {31'd0, io.snoop_wb}, {31'd0, e_wb});
      chk("dbg_state", {30'd0, io.dbg_state}, {30'd0, m_st[io.dbg_idx]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_req(input logic rw, input logic [3:0] idx, input logic [7:0] tag);
    int n = 0;
    while (!io.cpu_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, io.cpu_ready}, 32'd1);
    io.cpu_valid = 1'b1;
    io.cpu_rw    = rw;
    io.cpu_idx   = idx;
    io.cpu_tag   = tag;
    tick();
    io.cpu_valid = 1'b0;
  endtask

  task automatic grant();
    int n = 0;
    while (!io.bus_req && n < 20) begin
      tick();
      n++;
    end
    chk("gnt_wait_req", {31'd0, io.bus_req}, 32'd1);
    if (io.bus_req) begin
      io.bus_gnt = 1'b1;
      tick();
      io.bus_gnt = 1'b0;
    end
  endtask

  task automatic expect_done(input string name, input logic hit);
    int n = 0;
    while (!io.cpu_done && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_done"}, {31'd0, io.cpu_done}, 32'd1);
    chk({name, "_hit"}, {31'd0, io.cpu_hit}, {31'd0, hit});
  endtask

  task automatic snoop(input logic [1:0] cmd, input logic [3:0] idx, input logic [7:0] tag);
    io.snoop_valid = 1'b1;
    io.snoop_cmd   = cmd;
    io.snoop_idx   = idx;
    io.snoop_tag   = tag;
    tick();
    io.snoop_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    io.cpu_valid   = 1'b0;
    io.cpu_rw      = 1'b0;
    io.cpu_idx     = '0;
    io.cpu_tag     = '0;
    io.bus_gnt     = 1'b0;
    io.snoop_valid = 1'b0;
    io.snoop_cmd   = '0;
    io.snoop_idx   = '0;
    io.snoop_tag   = '0;
    io.dbg_idx     = 4'd3;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ready", {31'd0, io.cpu_ready}, 32'd1);
    chk("rst_bus_req", {31'd0, io.bus_req}, 32'd0);
    chk("rst_bus_cmd", {30'd0, io.bus_cmd}, 32'd0);
    chk("rst_bus_tag", {24'd0, io.bus_tag}, 32'd0);
    chk("rst_done", {31'd0, io.cpu_done}, 32'd0);

    // 1: read miss on an invalid line
    cpu_req(1'b0, 4'd3, 8'h12);
    chk("t1_req", {31'd0, io.bus_req}, 32'd1);
    chk("t1_cmd", {30'd0, io.bus_cmd}, 32'd2);
    chk("t1_idx", {28'd0, io.bus_idx}, 32'd3);
    tick();
    tick();
    grant();
    expect_done("t1", 1'b0);
    chk("t1_dbg", {30'd0, io.dbg_state}, 32'd2);

    // 2: read hit
    cpu_req(1'b0, 4'd3, 8'h12);
    expect_done("t2", 1'b1);
    chk("t2_no_req", {31'd0, io.bus_req}, 32'd0);

    // 3: upgrade, then conflict miss with write-back of a modified victim
    cpu_req(1'b1, 4'd3, 8'h12);
    chk("t3_inv_cmd", {30'd0, io.bus_cmd}, 32'd0);
    grant();
    expect_done("t3a", 1'b1);
    chk("t3_dbg_m", {30'd0, io.dbg_state}, 32'd1);
    cpu_req(1'b1, 4'd3, 8'h34);
    chk("t3_wb_cmd", {30'd0, io.bus_cmd}, 32'd3);
    chk("t3_wb_tag", {24'd0, io.bus_tag}, 32'h12);
    grant();
    chk("t3_wm_req", {31'd0, io.bus_req}, 32'd1);
    chk("t3_wm_cmd", {30'd0, io.bus_cmd}, 32'd1);
    chk("t3_wm_tag", {24'd0, io.bus_tag}, 32'h34);
    grant();
    expect_done("t3b", 1'b0);
    chk("t3_dbg_m2", {30'd0, io.dbg_state}, 32'd1);
    cpu_req(1'b0, 4'd3, 8'h34);
    expect_done("t3c", 1'b1);

    // 4: snoop transitions
    io.dbg_idx = 4'd5;
    cpu_req(1'b1, 4'd5, 8'h07);
    grant();
    expect_done("t4a", 1'b0);
    chk("t4_dbg_m", {30'd0, io.dbg_state}, 32'd1);
    snoop(C_RM, 4'd5, 8'h07);
    chk("t4_wb_pulse", {31'd0, io.snoop_wb}, 32'd1);
    chk("t4_dbg_s", {30'd0, io.dbg_state}, 32'd2);
    tick();
    chk("t4_wb_end", {31'd0, io.snoop_wb}, 32'd0);
    snoop(C_WM, 4'd5, 8'h07);
    chk("t4_dbg_i", {30'd0, io.dbg_state}, 32'd0);
    chk("t4_s_no_wb", {31'd0, io.snoop_wb}, 32'd0);
    cpu_req(1'b1, 4'd5, 8'h07);
    grant();
    expect_done("t4b", 1'b0);
    snoop(C_RM, 4'd5, 8'h08);
    chk("t4_tagmiss_dbg", {30'd0, io.dbg_state}, 32'd1);
    chk("t4_tagmiss_wb", {31'd0, io.snoop_wb}, 32'd0);
    io.dbg_idx = 4'd3;
    snoop(C_WM, 4'd3, 8'h34);
    chk("t4_m_wm_wb", {31'd0, io.snoop_wb}, 32'd1);
    chk("t4_m_wm_dbg", {30'd0, io.dbg_state}, 32'd0);

    // 5: upgrade lost to a snooped invalidate while the request is pending
    io.dbg_idx = 4'd2;
    cpu_req(1'b0, 4'd2, 8'h55);
    grant();
    expect_done("t5a", 1'b0);
    cpu_req(1'b1, 4'd2, 8'h55);
    chk("t5_inv", {30'd0, io.bus_cmd}, 32'd0);
    tick();
    snoop(C_INV, 4'd2, 8'h55);
    chk("t5_req_held", {31'd0, io.bus_req}, 32'd1);
    chk("t5_cmd_wm", {30'd0, io.bus_cmd}, 32'd1);
    chk("t5_dbg_i", {30'd0, io.dbg_state}, 32'd0);
    grant();
    expect_done("t5b", 1'b1);
    chk("t5_dbg_m", {30'd0, io.dbg_state}, 32'd1);

    // 6: reset in the middle of a bus request
    cpu_req(1'b0, 4'd7, 8'h01);
    chk("t6_req", {31'd0, io.bus_req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_req_drop", {31'd0, io.bus_req}, 32'd0);
    chk("t6_no_done", {31'd0, io.cpu_done}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < NL; i++) begin
      io.dbg_idx = 4'(i);
      tick();
      chk("t6_line_inv", {30'd0, io.dbg_state}, 32'd0);
      chk("t6_no_done_after", {31'd0, io.cpu_done}, 32'd0);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
